// File: rtl/pattern_pkg.sv
// Shared types and sizing helpers for the pattern_serializer front end.
// SERIAL_PARITY_EN adds one even-parity bit after each word's data bits.
package pattern_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int   DEFAULT_WIDTH    = 8;
  localparam logic DEFAULT_IDLE_BIT = 1'b0;

  // Serial bits emitted per word, including the parity bit when built.
  function automatic int nbits(input int width);
`ifdef SERIAL_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/pattern_serializer.sv
// Parallel-to-serial feeder for the bit-serial pattern recogniser; one bit per clock on a_out.
// Optional macro SERIAL_PARITY_EN appends an even-parity bit to every word.
module pattern_serializer
  import pattern_pkg::*;
#(
  parameter int   WIDTH     = DEFAULT_WIDTH,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = DEFAULT_IDLE_BIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             a_out,
  output logic             a_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int NBITS = nbits(WIDTH);
  localparam int CW    = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(NBITS - 1);

  state_t           state, next_state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             accept;
  logic             nxt;
`ifdef SERIAL_PARITY_EN
  logic             par;
`endif

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  // Ready depends only on registered state so no in_valid loop reaches upstream.
  assign last      = (cnt == LAST_CNT);
  assign in_ready  = (state == IDLE) | ((state == SHIFT) & last);
  assign accept    = in_valid & in_ready;
  assign busy      = (state == SHIFT);
  assign word_done = (state == SHIFT) & last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = SHIFT;
      SHIFT:   if (last && !accept) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Bit after the one on a_out: shreg keeps the displayed bit at its output end.
  always_comb begin
    nxt = MSB_FIRST ? shreg[WIDTH-2] : shreg[1];
`ifdef SERIAL_PARITY_EN
    if (cnt == CW'(WIDTH - 1)) nxt = par;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      cnt     <= '0;
      a_out   <= IDLE_BIT;
      a_valid <= 1'b0;
`ifdef SERIAL_PARITY_EN
      par     <= 1'b0;
`endif
    end else if (accept) begin
      // First bit goes straight to a_out so back-to-back words have no gap.
      shreg   <= in_data;
      cnt     <= '0;
      a_out   <= first_bit(in_data);
      a_valid <= 1'b1;
`ifdef SERIAL_PARITY_EN
      par     <= ^in_data;
`endif
    end else if (state == SHIFT) begin
      if (last) begin
        cnt     <= '0;
        a_out   <= IDLE_BIT;
        a_valid <= 1'b0;
      end else begin
        cnt     <= cnt + 1'b1;
        shreg   <= shift_word(shreg);
        a_out   <= nxt;
        a_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pattern_serializer.sv
// Self-checking bench for pattern_serializer: directed steps plus random words against a bit-queue model.
module tb_pattern_serializer;

  localparam int   W        = 8;
  localparam bit   MSBF     = 1'b1;
  localparam logic IDLE_LVL = 1'b0;
`ifdef SERIAL_PARITY_EN
  localparam int   NB       = W + 1;
`else
  localparam int   NB       = W;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         a_out;
  logic         a_valid;
  logic         word_done;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  // Model: bits of the word in flight, head is the bit currently on a_out.
  logic mq[$];
  logic [63:0] obs;
  int          obs_n;

  pattern_serializer #(.WIDTH(W), .MSB_FIRST(MSBF), .IDLE_BIT(IDLE_LVL)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .a_out(a_out), .a_valid(a_valid),
    .word_done(word_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [W-1:0] d);
    for (int i = 0; i < W; i++) mq.push_back(MSBF ? d[W-1-i] : d[i]);
`ifdef SERIAL_PARITY_EN
    mq.push_back(^d);
`endif
  endtask

  task automatic check_outputs();
    check("a_out",     a_out,     (mq.size() > 0) ? mq[0] : IDLE_LVL);
    check("a_valid",   a_valid,   mq.size() > 0);
    check("word_done", word_done, mq.size() == 1);
    check("busy",      busy,      mq.size() > 0);
    check("in_ready",  in_ready,  mq.size() <= 1);
  endtask

  // One clock: entered just after a falling edge, leaves just after the next one.
  task automatic cycle(input logic v, input logic [W-1:0] d, output logic acc);
    in_valid = v;
    in_data  = d;
    #1;
    check_outputs();
    acc = v && (mq.size() <= 1) && (rst === 1'b1);
    if (a_valid === 1'b1) begin
      obs = {obs[62:0], a_out};
      obs_n++;
    end
    @(posedge clk);
    if (mq.size() > 0) void'(mq.pop_front());
    if (acc) push_word(d);
    @(negedge clk);
  endtask

  task automatic clear_obs();
    obs   = '0;
    obs_n = 0;
  endtask

  logic        acc;
  int          n;
  logic [63:0] exp_stream;

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0;
    clear_obs();
    #2;
    check("rst_a_out", a_out, IDLE_LVL);
    check("rst_a_valid", a_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_word_done", word_done, 1'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // Idle: no word offered for 10 cycles.
    for (int i = 0; i < 10; i++) cycle(1'b0, W'($urandom), acc);
    check("idle_no_bits", obs_n, 0);

    // Single word D0.
    clear_obs();
    cycle(1'b1, 8'hD0, acc);
    check("d0_accept", acc, 1'b1);
    for (int i = 0; i < NB + 2; i++) cycle(1'b0, 8'h00, acc);
    check("d0_nbits", obs_n, NB);
`ifdef SERIAL_PARITY_EN
    check("d0_stream", obs[NB-1:0], 9'b110100001);
`else
    check("d0_stream", obs[NB-1:0], 8'b11010000);
`endif

    // Back-to-back D0 then 0D with in_valid held.
    clear_obs();
    cycle(1'b1, 8'hD0, acc);
    n = 0;
    do begin
      cycle(1'b1, 8'h0D, acc);
      n++;
    end while (!acc && n < 20);
    check("b2b_wait", n, NB);
    for (int i = 0; i < NB + 2; i++) cycle(1'b0, 8'h00, acc);
    check("b2b_nbits", obs_n, 2 * NB);
`ifdef SERIAL_PARITY_EN
    exp_stream = 64'({9'b110100001, 9'b000011011});
`else
    exp_stream = 64'({8'b11010000, 8'b00001101});
`endif
    check("b2b_stream", obs[2*NB-1:0], exp_stream[2*NB-1:0]);

    // FF held while busy: accepted only on the last-bit cycle.
    cycle(1'b1, 8'h5A, acc);
    n = 0;
    do begin
      cycle(1'b1, 8'hFF, acc);
      n++;
    end while (!acc && n < 20);
    check("hold_ff_wait", n, NB);
    for (int i = 0; i < NB + 1; i++) cycle(1'b0, 8'h00, acc);

    // Reset asserted at bit 3 of B4.
    cycle(1'b1, 8'hB4, acc);
    cycle(1'b0, 8'h00, acc);
    cycle(1'b0, 8'h00, acc);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    mq.delete();
    check("midrst_a_out", a_out, 1'b0);
    check("midrst_a_valid", a_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    @(negedge clk);
    cycle(1'b1, 8'hFF, acc);
    cycle(1'b1, 8'h3C, acc);
    rst = 1'b1;
    clear_obs();
    cycle(1'b1, 8'h81, acc);
    for (int i = 0; i < NB + 2; i++) cycle(1'b0, 8'h00, acc);
    check("post_rst_nbits", obs_n, NB);
`ifdef SERIAL_PARITY_EN
    check("post_rst_stream", obs[NB-1:0], 9'b100000010);
`else
    check("post_rst_stream", obs[NB-1:0], 8'b10000001);
`endif

    // Random traffic: valid gaps, data changing while held.
    for (int i = 0; i < 300; i++) cycle($urandom_range(0, 3) != 0, W'($urandom), acc);
    for (int i = 0; i < NB + 2; i++) cycle(1'b0, 8'h00, acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pattern_serializer.md
Name: pattern_serializer

Overview:
Parallel-to-serial front end that feeds the bit-serial pattern recogniser FSM.
Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on a_out, which drives the recogniser's serial input a directly.
Supports back-to-back words with no idle bit between them; drives a fixed idle level when no word is in flight.

Parameters:
WIDTH, 8, word width in bits (>= 2)
MSB_FIRST, 1, 1 = shift MSB first, 0 = LSB first
IDLE_BIT, 1'b0, level driven on a_out when not shifting (0 forces the recogniser back to its start state)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
in_data  input  WIDTH  parallel word
in_valid  input  1  in_data valid
in_ready  output  1  serializer can accept a word this cycle
a_out  output  1  serial bit to recogniser input a (registered)
a_valid  output  1  a_out carries a data bit (registered)
word_done  output  1  one-cycle pulse, coincident with the last bit of a word
busy  output  1  state == SHIFT

Behaviour:
- Reset (rst low, async): state=IDLE, shreg=0, cnt=0, a_out=IDLE_BIT, a_valid=0, word_done=0, busy=0. Handshakes are ignored while rst is low.
- States: IDLE, SHIFT. cnt is $clog2(WIDTH+1) bits wide and counts bits already emitted for the current word.
- in_ready = (state==IDLE) | (state==SHIFT & last), where last = (cnt==NBITS-1). NBITS = WIDTH, or WIDTH+1 with the optional feature. in_ready is combinational from state and cnt only, never from in_valid.
- Accept = in_valid & in_ready. On accept, load shreg with in_data and set cnt=0 on the next edge. The first bit appears on a_out one cycle after the accept edge (latency 1).
- IDLE: a_out=IDLE_BIT, a_valid=0. Accept -> SHIFT.
- SHIFT: each cycle present the next bit (MSB_FIRST: shreg[WIDTH-1] then shift left; else shreg[0] then shift right). Hold a_valid=1 and increment cnt.
- On the last bit: word_done=1 in the same cycle. If accept also occurs that cycle, reload and stay in SHIFT; the next word's first bit follows with no gap. Otherwise return to IDLE and a_out reverts to IDLE_BIT on the following cycle.
- in_data may change freely after accept; the captured copy is used.
- in_valid without in_ready: no capture, no state change. Upstream must hold the word.
- Reset mid-word: the word is discarded immediately and outputs take their reset values asynchronously.
- No combinational path from in_valid or in_data to a_out.

Optional Feature:
SERIAL_PARITY_EN:
- When defined, an even-parity bit (XOR of the captured word) is emitted as bit NBITS-1 after the WIDTH data bits, with a_valid=1. word_done then coincides with the parity bit.
- When undefined, NBITS=WIDTH, no parity logic is built, and ports are unchanged.

Decomposition:
- pattern_pkg holds:
  - the state enum (IDLE, SHIFT);
  - default WIDTH and IDLE_BIT constants;
  - a function computing NBITS from WIDTH and the macro.
- Single flat module. A sub-module is not warranted; shift register, counter and FSM fit in one file.

Test Plan:
- Reset then idle, in_valid=0 for 10 cycles -> a_out=0, a_valid=0, in_ready=1, word_done never asserts.
- WIDTH=8, MSB_FIRST=1, accept 8'hD0 -> a_out = 1,1,0,1,0,0,0,0 on cycles 1..8 after accept; word_done on cycle 8. A downstream recogniser asserts y the cycle after the 4th bit.
- Back-to-back 8'hD0 then 8'h0D (second presented with in_valid held) -> second accepted on the first word's last-bit cycle; 16 contiguous a_valid cycles; stream 11010000 00001101.
- in_valid held high with 8'hFF while busy -> in_ready=0 for cycles 1..7 of the current word; no capture until the last-bit cycle.
- Assert rst low at bit 3 of 8'hB4 -> a_out=0, a_valid=0, busy=0 immediately; after release a new word 8'h81 serializes cleanly as 1,0,0,0,0,0,0,1.
- With SERIAL_PARITY_EN, accept 8'hD0 -> 9 valid bits, 9th bit = 1 (three ones); word_done on the 9th bit. 8'h0F -> 9th bit = 0.
